mips_multi_ctrl: RTL and testbench

Parametrised successor to the multicycle MIPS controller. It is the state-machine controller between the instruction register fields and the multicycle datapath. Compared with the current controller it adds:
- an optional memory ready/wait handshake
- immediate ALU ops (addi/andi/ori/slti), bne and jal
- a sticky illegal-instruction trap
- a retired-instruction counter

It drives the existing datapath plus a 2-bit regdst/memtoreg and a zero-extend select.

---
 rtl/mips_multi_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_multi_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS controller: decodes the IR opcode/funct fields into datapath controls.
// Adds a memory wait handshake, immediate ALU ops, bne/jal, a sticky illegal trap and an instret counter.
module mips_multi_ctrl #(
    parameter bit          MEM_HANDSHAKE = 1'b0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memreq,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             pcen,
    output logic             iord,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             extop,
    output logic [1:0]       pcsrc,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMEX, S_IMMWB,
        S_JEX, S_JALEX, S_ILLEGAL
    } state_e;

    state_e           state_q, state_d, cur_state;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic             rdy;
    logic             retire;
    logic             r_legal;
    logic [2:0]       r_alu;
    logic [2:0]       imm_alu;
    logic             imm_zext;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
    end

    // Logical immediates are zero-extended; arithmetic and compare immediates are sign-extended.
    always_comb begin
        imm_alu  = ALU_ADD;
        imm_zext = 1'b0;
        case (op)
            OP_ANDI: begin imm_alu = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
            OP_SLTI: imm_alu = ALU_SLT;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // While reset is high the outputs show the FETCH decode, with every write enable suppressed.
    assign cur_state = reset ? S_FETCH : state_q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        memreq     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        pcen       = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        extop      = 1'b0;
        pcsrc      = 2'b00;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alucontrol = ALU_ADD;
        retire     = 1'b0;
        state_d    = state_q;

        case (cur_state)
            S_FETCH: begin
                memreq  = 1'b1;
                alusrcb = 2'b01;
                irwrite = rdy;
                pcen    = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = r_legal ? S_RTYPEEX : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:         state_d = S_JEX;
                    OP_JAL:       state_d = S_JALEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memreq   = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
                state_d    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (cur_state == S_BEQEX) ? zero : ~zero;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = imm_alu;
                extop      = imm_zext;
                state_d    = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                alucontrol = imm_alu;
                extop      = imm_zext;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX, S_JALEX: begin
                pcen  = 1'b1;
                pcsrc = 2'b10;
                if (cur_state == S_JALEX) begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase

        if (reset) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
            retire   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
            if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q & ~reset;
    assign instret = instret_q;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: one instance with the memory handshake, one without and a 2-bit counter.
// A per-instruction phase model (fetch/decode/execute/memory/writeback) predicts every cycle's controls.
module tb_mips_multi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_hs, rst_nh;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       memreq_hs, memwrite_hs, irwrite_hs, regwrite_hs, pcen_hs, iord_hs, alusrca_hs;
    logic [1:0] alusrcb_hs, pcsrc_hs, regdst_hs, memtoreg_hs;
    logic       extop_hs, illegal_hs;
    logic [2:0] alucontrol_hs;
    logic [31:0] instret_hs;

    logic       memreq_nh, memwrite_nh, irwrite_nh, regwrite_nh, pcen_nh, iord_nh, alusrca_nh;
    logic [1:0] alusrcb_nh, pcsrc_nh, regdst_nh, memtoreg_nh;
    logic       extop_nh, illegal_nh;
    logic [2:0] alucontrol_nh;
    logic [1:0] instret_nh;

    mips_multi_ctrl #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) u_hs (
        .clk(clk), .reset(rst_hs), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memreq(memreq_hs), .memwrite(memwrite_hs), .irwrite(irwrite_hs), .regwrite(regwrite_hs),
        .pcen(pcen_hs), .iord(iord_hs), .alusrca(alusrca_hs), .alusrcb(alusrcb_hs), .extop(extop_hs),
        .pcsrc(pcsrc_hs), .regdst(regdst_hs), .memtoreg(memtoreg_hs), .alucontrol(alucontrol_hs),
        .illegal(illegal_hs), .instret(instret_hs)
    );

    mips_multi_ctrl #(.MEM_HANDSHAKE(1'b0), .CNT_W(2)) u_nh (
        .clk(clk), .reset(rst_nh), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memreq(memreq_nh), .memwrite(memwrite_nh), .irwrite(irwrite_nh), .regwrite(regwrite_nh),
        .pcen(pcen_nh), .iord(iord_nh), .alusrca(alusrca_nh), .alusrcb(alusrcb_nh), .extop(extop_nh),
        .pcsrc(pcsrc_nh), .regdst(regdst_nh), .memtoreg(memtoreg_nh), .alucontrol(alucontrol_nh),
        .illegal(illegal_nh), .instret(instret_nh)
    );

    typedef struct packed {
        logic       memreq, memwrite, irwrite, regwrite, pcen, iord, alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [1:0] pcsrc, regdst, memtoreg;
        logic [2:0] alu;
        logic       illegal;
    } ctl_t;

    typedef enum int { C_LW, C_SW, C_R, C_IMM, C_BEQ, C_BNE, C_J, C_JAL, C_ILL } cls_e;
    typedef enum int { PH_F, PH_D, PH_E, PH_M, PH_W, PH_T } ph_e;

    logic        sel_hs;
    logic [19:0] obs_hs, obs_nh, obs;
    logic [31:0] obs_cnt;
    logic [31:0] model_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs_hs  = {memreq_hs, memwrite_hs, irwrite_hs, regwrite_hs, pcen_hs, iord_hs, alusrca_hs,
                      alusrcb_hs, extop_hs, pcsrc_hs, regdst_hs, memtoreg_hs, alucontrol_hs, illegal_hs};
    assign obs_nh  = {memreq_nh, memwrite_nh, irwrite_nh, regwrite_nh, pcen_nh, iord_nh, alusrca_nh,
                      alusrcb_nh, extop_nh, pcsrc_nh, regdst_nh, memtoreg_nh, alucontrol_nh, illegal_nh};
    assign obs     = sel_hs ? obs_hs : obs_nh;
    assign obs_cnt = sel_hs ? instret_hs : {30'b0, instret_nh};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cls_e cls_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b101010) ? C_R : C_ILL;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return C_IMM;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    // ALU operation implied by the instruction's meaning.
    function automatic logic [2:0] alu_for(input cls_e c, input logic [5:0] o, input logic [5:0] f);
        if (c == C_R) begin
            case (f)
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b010;
            endcase
        end
        case (o)
            6'b001100: return 3'b000;
            6'b001101: return 3'b001;
            6'b001010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input cls_e c, input ph_e ph, input logic [5:0] o,
                                        input logic [5:0] f, input logic z, input logic r);
        ctl_t e;
        logic zext;
        e     = '0;
        e.alu = 3'b010;
        zext  = (o == 6'b001100 || o == 6'b001101);
        case (ph)
            PH_F: begin
                e.memreq = 1'b1; e.alusrcb = 2'b01; e.irwrite = r; e.pcen = r;
            end
            PH_D: e.alusrcb = 2'b11;
            PH_E: begin
                case (c)
                    C_LW, C_SW: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    C_R: begin e.alusrca = 1'b1; e.alu = alu_for(c, o, f); end
                    C_IMM: begin
                        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = alu_for(c, o, f); e.extop = zext;
                    end
                    C_BEQ, C_BNE: begin
                        e.alusrca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01;
                        e.pcen = (c == C_BEQ) ? z : ~z;
                    end
                    C_J: begin e.pcen = 1'b1; e.pcsrc = 2'b10; end
                    C_JAL: begin
                        e.pcen = 1'b1; e.pcsrc = 2'b10; e.regwrite = 1'b1;
                        e.regdst = 2'b10; e.memtoreg = 2'b10;
                    end
                    default: e.alu = 3'b010;
                endcase
            end
            PH_M: begin
                e.memreq = 1'b1; e.iord = 1'b1; e.memwrite = (c == C_SW);
            end
            PH_W: begin
                e.regwrite = 1'b1;
                if (c == C_LW) e.memtoreg = 2'b01;
                if (c == C_R) e.regdst = 2'b01;
                if (c == C_IMM) begin e.alu = alu_for(c, o, f); e.extop = zext; end
            end
            PH_T: e.illegal = 1'b1;
            default: e.alu = 3'b010;
        endcase
        return e;
    endfunction

    // Starts and ends on a falling edge; leaves the selected DUT in FETCH with the count cleared.
    task automatic reset_pulse();
        ctl_t e;
        if (sel_hs) rst_hs = 1'b1; else rst_nh = 1'b1;
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
        e = expect_ctl(C_ILL, PH_F, op, funct, zero, 1'b0);
        e.memreq = 1'b0;
        #1;
        check("reset_ctl", {12'b0, obs}, {12'b0, e});
        @(negedge clk);
        check("reset_instret", obs_cnt, 32'd0);
        if (sel_hs) rst_hs = 1'b0; else rst_nh = 1'b0;
        model_cnt = 32'd0;
    endtask

    // zmode: 0 random, 1 zero=0, 2 zero=1. fwaits/mwaits: forced wait cycles, -1 random.
    // abort_cyc: reset is applied at that cycle of the instruction (-1 never).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int fwaits, input int mwaits, input int abort_cyc);
        cls_e  c;
        ph_e   plan[12];
        int    n, cyc, waits, limit;
        logic  r, adv;
        ctl_t  e;
        logic [31:0] mask;
        op    = o;
        funct = f;
        c     = cls_of(o, f);
        mask  = sel_hs ? 32'hFFFF_FFFF : 32'h0000_0003;
        plan[0] = PH_F;
        plan[1] = PH_D;
        plan[2] = PH_E;
        n = 3;
        case (c)
            C_LW:  begin plan[3] = PH_M; plan[4] = PH_W; n = 5; end
            C_SW:  begin plan[3] = PH_M; n = 4; end
            C_R, C_IMM: begin plan[3] = PH_W; n = 4; end
            C_ILL: begin
                for (int i = 2; i < 12; i++) plan[i] = PH_T;
                n = 12;
            end
            default: n = 3;
        endcase
        cyc = 0;
        for (int p = 0; p < n; p++) begin
            waits = 0;
            adv   = 1'b0;
            while (!adv) begin
                if (cyc == abort_cyc) begin
                    reset_pulse();
                    return;
                end
                case (zmode)
                    1: zero = 1'b0;
                    2: zero = 1'b1;
                    default: zero = 1'($urandom);
                endcase
                limit = (plan[p] == PH_F) ? fwaits : mwaits;
                if (limit >= 0) mem_ready = (waits >= limit);
                else mem_ready = (waits >= 5) ? 1'b1 : ($urandom_range(0, 2) != 0);
                r = sel_hs ? mem_ready : 1'b1;
                e = expect_ctl(c, plan[p], o, f, zero, r);
                #1;
                check($sformatf("ctl op=%b f=%b ph=%0d", o, f, plan[p]), {12'b0, obs}, {12'b0, e});
                check("instret", obs_cnt, model_cnt);
                adv = (plan[p] == PH_F || plan[p] == PH_M) ? r : 1'b1;
                if (!adv) waits++;
                if (adv && p == n - 1 && c != C_ILL) model_cnt = (model_cnt + 32'd1) & mask;
                cyc++;
                @(negedge clk);
            end
        end
    endtask

    logic [5:0] legal_ops [15];
    logic [5:0] legal_fn  [15];

    task automatic random_run(input int count);
        int k, ab;
        logic [5:0] fn;
        for (int i = 0; i < count; i++) begin
            k  = $urandom_range(0, 14);
            fn = (legal_ops[k] == 6'b000000) ? legal_fn[k] : 6'($urandom);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            run_instr(legal_ops[k], fn, 0, -1, -1, ab);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                      6'b000100, 6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                      6'b000010, 6'b000011};
        legal_fn  = '{6'b0, 6'b0, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                      6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        rst_hs = 1'b1; rst_nh = 1'b1;
        op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        sel_hs = 1'b0; model_cnt = 32'd0;
        repeat (2) @(negedge clk);

        // No-handshake instance, 2-bit counter.
        reset_pulse();
        run_instr(6'b001000, 6'b000101, 0, -1, -1, -1);  // addi $2,$0,5
        run_instr(6'b000101, 6'b000010, 1, -1, -1, -1);  // bne taken (zero=0)
        run_instr(6'b000010, 6'b000000, 0, -1, -1, -1);  // j
        check("instret_after_jump", obs_cnt, 32'd3);
        run_instr(6'b100011, 6'b000000, 0, -1, -1, -1);  // lw
        run_instr(6'b101011, 6'b000000, 0, -1, -1, -1);  // sw
        check("instret_wrap", obs_cnt, 32'd1);
        run_instr(6'b000100, 6'b0, 2, -1, -1, -1);       // beq zero=1
        run_instr(6'b000100, 6'b0, 1, -1, -1, -1);       // beq zero=0
        run_instr(6'b000101, 6'b0, 2, -1, -1, -1);       // bne zero=1
        run_instr(6'b000101, 6'b0, 1, -1, -1, -1);       // bne zero=0
        random_run(30);
        run_instr(6'b111111, 6'b0, 0, -1, -1, -1);       // unknown opcode
        reset_pulse();
        run_instr(6'b000000, 6'b100000, 0, -1, -1, -1);

        // Handshake instance, 32-bit counter.
        rst_nh = 1'b1;
        sel_hs = 1'b1;
        reset_pulse();
        run_instr(6'b001000, 6'b0, 0, 3, -1, -1);        // three fetch wait cycles
        run_instr(6'b101011, 6'b0, 0, 0, 2, -1);         // sw with two write waits
        run_instr(6'b100011, 6'b0, 0, 1, 3, -1);         // lw with waits
        run_instr(6'b001100, 6'b111111, 0, -1, -1, -1);  // andi $3,$1,0xFFFF
        run_instr(6'b001010, 6'b0, 0, -1, -1, -1);       // slti
        run_instr(6'b001101, 6'b0, 0, -1, -1, -1);       // ori
        run_instr(6'b000011, 6'b0, 0, -1, -1, -1);       // jal
        random_run(60);
        run_instr(6'b000000, 6'b000111, 0, -1, -1, -1);  // illegal R funct
        reset_pulse();
        random_run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
